// File: rtl/cfg_write_arbiter_if.sv
// Bundle of requester, regmap-write and status signals around cfg_write_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface cfg_write_arbiter_if #(
    parameter int N_REQ    = 3,
    parameter int ERRCNT_W = 16
);
    logic [N_REQ-1:0]    req_valid;
    logic [8*N_REQ-1:0]  req_addr;
    logic [32*N_REQ-1:0] req_data;
    logic [32*N_REQ-1:0] req_keep;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_done;
    logic [1:0]          rsp_err;
    logic                rsp_timeout;
    logic                wr_cmd;
    logic [7:0]          wr_addr;
    logic [31:0]         wr_data;
    logic [31:0]         wr_keep;
    logic                wr_valid;
    logic                wr_ready;
    logic [1:0]          wr_err;
    logic                busy;
    logic [2:0]          grant_idx;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        input  req_valid, req_addr, req_data, req_keep, wr_valid, wr_ready, wr_err,
        output req_ready, rsp_done, rsp_err, rsp_timeout, wr_cmd, wr_addr, wr_data,
               wr_keep, busy, grant_idx, err_count
    );

    modport slave (
        output req_valid, req_addr, req_data, req_keep, wr_valid, wr_ready, wr_err,
        input  req_ready, rsp_done, rsp_err, rsp_timeout, wr_cmd, wr_addr, wr_data,
               wr_keep, busy, grant_idx, err_count
    );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Round-robin arbiter sharing the config_reg_map write port among N_REQ requesters,
// one write in flight, with per-write completion status and a saturating failure count.
module cfg_write_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ERRCNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    cfg_write_arbiter_if.master  bus
);
    localparam int IW = 3;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [7:0]          addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         keep_q, keep_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [1:0]          err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;

    logic [IW-1:0]       pick;
    logic                any_valid;
    logic [N_REQ-1:0]    req_ready_c;

    // The rst_n_i name is inherited, but the reset is asserted high.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= IW'(N_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            timer_q      <= '0;
            err_q        <= '0;
            tmo_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
        end
    end

    // Scan distances N_REQ..1 so the closest valid requester after last_grant wins.
    always_comb begin
        pick      = last_grant_q;
        any_valid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && (i == (int'(last_grant_q) + k) % N_REQ)) begin
                    pick      = IW'(i);
                    any_valid = 1'b1;
                end
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        keep_d       = keep_q;
        timer_d      = timer_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        req_ready_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.wr_ready && any_valid) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick == IW'(i)) begin
                            req_ready_c[i] = 1'b1;
                            addr_d         = bus.req_addr[8*i +: 8];
                            data_d         = bus.req_data[32*i +: 32];
                            keep_d         = bus.req_keep[32*i +: 32];
                        end
                    end
                    grant_d = pick;
                    err_d   = 2'b00;
                    tmo_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (bus.wr_err != 2'b00) begin
                    err_d   = bus.wr_err;
                    state_d = S_RESP;
                end else if (bus.wr_valid) begin
                    state_d = S_RESP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                if ((err_q != 2'b00 || tmo_q) && cnt_q != '1) begin
                    cnt_d = cnt_q + ERRCNT_W'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // req_ready is combinational, so it is gated directly by reset to be 0 while reset is held.
    always_comb begin
        bus.req_ready = rst_n_i ? '0 : req_ready_c;
        bus.rsp_done  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.rsp_done[i] = (state_q == S_RESP) && (grant_q == IW'(i));
        end
        bus.rsp_err     = (state_q == S_RESP) ? err_q : 2'b00;
        bus.rsp_timeout = (state_q == S_RESP) && tmo_q;
        bus.wr_cmd      = (state_q == S_ISSUE);
        bus.wr_addr     = addr_q;
        bus.wr_data     = data_q;
        bus.wr_keep     = keep_q;
        bus.busy        = (state_q != S_IDLE);
        bus.grant_idx   = grant_q;
        bus.err_count   = cnt_q;
    end
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Scoreboard bench for cfg_write_arbiter: tests push expected writes/completions,
// a monitor records what the DUT produced, and each test compares the two.
module tb_cfg_write_arbiter;
    localparam int N  = 3;
    localparam int TO = 64;

    typedef enum {M_OK, M_ERR, M_NEVER} mode_e;
    typedef struct {int cyc; logic [2:0] g; logic [7:0] a; logic [31:0] d; logic [31:0] k;} cmd_t;
    typedef struct {int cyc; logic [N-1:0] done; logic [1:0] err; logic tmo;} rsp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    mode_e mode = M_OK;
    logic [2:0] m_last;

    cmd_t exp_cmd[$], obs_cmd[$];
    rsp_t exp_rsp[$], obs_rsp[$];

    cfg_write_arbiter_if #(.N_REQ(N), .ERRCNT_W(16)) bus ();

    cfg_write_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .ERRCNT_W(16)) dut (
        .clk_i  (clk),
        .rst_n_i(rst),
        .bus    (bus)
    );

    always #4 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: record every write strobe and completion pulse.
    initial forever begin
        @(negedge clk);
        if (bus.wr_cmd === 1'b1)
            obs_cmd.push_back('{cyc, bus.grant_idx, bus.wr_addr, bus.wr_data, bus.wr_keep});
        if (|bus.rsp_done)
            obs_rsp.push_back('{cyc, bus.rsp_done, bus.rsp_err, bus.rsp_timeout});
    end

    // Regmap responder: answers one cycle after wr_cmd according to mode.
    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_err   = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.wr_cmd === 1'b1 && mode != M_NEVER) begin
                @(posedge clk); #1;
                bus.wr_valid = 1'b1;
                bus.wr_err   = (mode == M_ERR) ? 2'b11 : 2'b00;
                @(posedge clk); #1;
                bus.wr_valid = 1'b0;
                bus.wr_err   = 2'b00;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [N-1:0] v);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (int'(last) + k) % N;
            if (v[i]) return 3'(i);
        end
        return last;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (obs_rsp.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d, input logic [31:0] k);
        bus.req_addr[8*i +: 8]   = a;
        bus.req_data[32*i +: 32] = d;
        bus.req_keep[32*i +: 32] = k;
    endtask

    task automatic push_exp(input int ccyc, input int rcyc, input logic [2:0] g, input logic [1:0] err,
                            input logic tmo);
        exp_cmd.push_back('{ccyc, g, bus.req_addr[8*g +: 8], bus.req_data[32*g +: 32],
                            bus.req_keep[32*g +: 32]});
        exp_rsp.push_back('{rcyc, N'(1) << g, err, tmo});
    endtask

    task automatic scoreboard_drain(input string tag);
        while (exp_cmd.size() > 0) begin
            cmd_t e, o;
            e = exp_cmd.pop_front();
            vectors++;
            if (obs_cmd.size() == 0) begin
                miscompares++;
                $display("FAIL %s wr_cmd: got no strobe, expected grant %0d addr %h", tag, e.g, e.a);
            end else begin
                o = obs_cmd.pop_front();
                if (o.g !== e.g || o.a !== e.a || o.d !== e.d || o.k !== e.k || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                    miscompares++;
                    $display("FAIL %s wr_cmd: got g=%0d a=%h d=%h k=%h cyc=%0d, expected g=%0d a=%h d=%h k=%h cyc=%0d",
                             tag, o.g, o.a, o.d, o.k, o.cyc, e.g, e.a, e.d, e.k, e.cyc);
                end
            end
        end
        vectors++;
        if (obs_cmd.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra wr_cmd: got %0d extra, expected 0", tag, obs_cmd.size());
        end
        obs_cmd.delete();
        while (exp_rsp.size() > 0) begin
            rsp_t e, o;
            e = exp_rsp.pop_front();
            vectors++;
            if (obs_rsp.size() == 0) begin
                miscompares++;
                $display("FAIL %s rsp_done: got no pulse, expected %b", tag, e.done);
            end else begin
                o = obs_rsp.pop_front();
                if (o.done !== e.done || o.err !== e.err || o.tmo !== e.tmo || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                    miscompares++;
                    $display("FAIL %s rsp: got done=%b err=%b tmo=%b cyc=%0d, expected done=%b err=%b tmo=%b cyc=%0d",
                             tag, o.done, o.err, o.tmo, o.cyc, e.done, e.err, e.tmo, e.cyc);
                end
            end
        end
        vectors++;
        if (obs_rsp.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra rsp_done: got %0d extra, expected 0", tag, obs_rsp.size());
        end
        obs_rsp.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.wr_ready  = 1'b1;
        repeat (3) step();
        vectors++;
        if ({bus.busy, bus.wr_cmd, bus.rsp_done, bus.req_ready, bus.rsp_err, bus.rsp_timeout, bus.grant_idx,
             bus.err_count, bus.wr_addr, bus.wr_data, bus.wr_keep} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b req_ready=%b grant=%0d err_count=%0d, expected all 0",
                     bus.busy, bus.req_ready, bus.grant_idx, bus.err_count);
        end
        bus.req_valid = '0;
        rst = 1'b0;
        m_last = 3'(N - 1);
        step();
    endtask

    task automatic test_single_write();
        int t;
        mode = M_OK;
        set_req(0, 8'h05, 32'd20, 32'hFFFF_FFFF);
        bus.req_valid = 3'b001;
        @(negedge clk);
        t = cyc;
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL single req_ready: got %b, expected 001", bus.req_ready);
        end
        push_exp(t + 1, t + 3, rr_pick(m_last, 3'b001), 2'b00, 1'b0);
        m_last = rr_pick(m_last, 3'b001);
        step();
        bus.req_valid = '0;
        begin
            bit ok;
            wait_rsp(1, 20, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL single timeout: got no rsp_done, expected one within 20 cycles");
            end
        end
        repeat (2) step();
        scoreboard_drain("single");
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [2:0] g;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_last = 3'(N - 1);
        for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i), 32'hA000_0000 + i, 32'h0F0F_0000 | i);
        bus.req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            g = rr_pick(m_last, 3'b111);
            push_exp(-1, -1, g, 2'b00, 1'b0);
            m_last = g;
        end
        wait_rsp(6, 100, ok);
        bus.req_valid = '0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL round_robin timeout: got %0d completions, expected 6", obs_rsp.size());
        end
        repeat (3) step();
        vectors++;
        if (bus.busy !== 1'b0 || bus.err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL round_robin idle: got busy=%b err_count=%0d, expected 0 0", bus.busy, bus.err_count);
        end
        scoreboard_drain("round_robin");
    endtask

    task automatic test_error_priority();
        bit ok;
        mode = M_ERR;
        set_req(1, 8'hFF, 32'h1234_5678, 32'h0000_00FF);
        bus.req_valid = 3'b010;
        push_exp(-1, -1, rr_pick(m_last, 3'b010), 2'b11, 1'b0);
        m_last = rr_pick(m_last, 3'b010);
        step();
        bus.req_valid = '0;
        wait_rsp(1, 20, ok);
        vectors++;
        if (!ok || bus.err_count !== 16'd1) begin
            miscompares++;
            $display("FAIL error err_count: got %0d (done=%b), expected 1", bus.err_count, ok);
        end
        step();
        scoreboard_drain("error");
    endtask

    task automatic test_timeout();
        bit ok;
        int t;
        mode = M_NEVER;
        set_req(2, 8'h33, 32'hDEAD_BEEF, 32'hFFFF_0000);
        bus.req_valid = 3'b100;
        @(negedge clk);
        t = cyc;
        push_exp(t + 1, t + 2 + TO, rr_pick(m_last, 3'b100), 2'b00, 1'b1);
        m_last = rr_pick(m_last, 3'b100);
        step();
        bus.req_valid = '0;
        wait_rsp(1, 200, ok);
        vectors++;
        if (!ok || bus.err_count !== 16'd2) begin
            miscompares++;
            $display("FAIL timeout err_count: got %0d (done=%b), expected 2", bus.err_count, ok);
        end
        step();
        scoreboard_drain("timeout");
    endtask

    task automatic test_not_ready();
        bit ok;
        mode = M_OK;
        bus.wr_ready = 1'b0;
        set_req(1, 8'h44, 32'h0000_0044, 32'h0000_FFFF);
        bus.req_valid = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== 3'b000 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL not_ready cycle %0d: got req_ready=%b busy=%b, expected 000 0", i, bus.req_ready, bus.busy);
            end
        end
        step();
        bus.wr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL not_ready raise: got req_ready=%b, expected 010", bus.req_ready);
        end
        push_exp(-1, -1, rr_pick(m_last, 3'b010), 2'b00, 1'b0);
        m_last = rr_pick(m_last, 3'b010);
        step();
        bus.req_valid = '0;
        wait_rsp(1, 20, ok);
        step();
        scoreboard_drain("not_ready");
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        mode = M_NEVER;
        set_req(0, 8'h55, 32'h5555_5555, 32'hFFFF_FFFF);
        bus.req_valid = 3'b001;
        exp_cmd.push_back('{-1, rr_pick(m_last, 3'b001), 8'h55, 32'h5555_5555, 32'hFFFF_FFFF});
        step();
        bus.req_valid = '0;
        repeat (4) step();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wait busy: got %b, expected 1", bus.busy);
        end
        rst = 1'b1;
        bus.req_valid = 3'b111;
        #1;
        vectors++;
        if ({bus.busy, bus.wr_cmd, bus.rsp_done, bus.req_ready, bus.rsp_err, bus.rsp_timeout, bus.grant_idx,
             bus.err_count, bus.wr_addr, bus.wr_data, bus.wr_keep} !== '0) begin
            miscompares++;
            $display("FAIL reset_wait outputs: got busy=%b grant=%0d err_count=%0d wr_addr=%h, expected all 0",
                     bus.busy, bus.grant_idx, bus.err_count, bus.wr_addr);
        end
        repeat (3) step();
        vectors++;
        if (obs_rsp.size() != 0 || bus.req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_wait held: got %0d rsp_done, req_ready=%b, expected 0 000", obs_rsp.size(), bus.req_ready);
        end
        mode = M_OK;
        for (int i = 0; i < N; i++) set_req(i, 8'h60 + 8'(i), 32'hC000_0000 + i, 32'h00FF_00FF);
        rst = 1'b0;
        m_last = 3'(N - 1);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_wait first_grant: got req_ready=%b, expected 001", bus.req_ready);
        end
        push_exp(-1, -1, rr_pick(m_last, 3'b111), 2'b00, 1'b0);
        m_last = rr_pick(m_last, 3'b111);
        step();
        bus.req_valid = '0;
        wait_rsp(1, 20, ok);
        step();
        scoreboard_drain("reset_wait");
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_keep  = '0;
        bus.wr_ready  = 1'b1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_error_priority();
        test_timeout();
        test_not_ready();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
